// File: rtl/muskbus_pkg.sv
// Shared Muskbus definitions: default bus widths, a helper to size requester-ID
// fields, and the request-FSM state type used by Muskbus arbiters.
package muskbus_pkg;

  localparam int unsigned DefDataW     = 64;
  localparam int unsigned DefTagW      = 13;
  localparam int unsigned DefRespBeats = 8;

  // Width of an index into n items; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    StIdle  = 1'b0,
    StIssue = 1'b1
  } req_state_e;

endpackage

// File: rtl/muskbus_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   eligible  in   N     candidates that may be picked
//   rr_ptr    in   ID_W  last winner; search starts at rr_ptr+1 mod N
//   hit       out  1     at least one candidate is eligible
//   idx       out  ID_W  chosen candidate (0 when no hit)
module muskbus_rr_pick #(
  parameter int unsigned N    = 2,
  parameter int unsigned ID_W = 1
) (
  input  logic [N-1:0]    eligible,
  input  logic [ID_W-1:0] rr_ptr,
  output logic            hit,
  output logic [ID_W-1:0] idx
);

  int unsigned cand;

  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    cand = 0;
    // Walk from the farthest candidate to the nearest so the one right after
    // rr_ptr overwrites any earlier match.
    for (int k = int'(N); k >= 1; k--) begin
      cand = (int'(rr_ptr) + k) % N;
      if (eligible[cand]) begin
        hit = 1'b1;
        idx = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/muskbus_tagged_arbiter.sv
// Shares one Muskbus top port between N requesters. The top request channel is
// granted to one requester for a single request, then released, so several
// requests may be outstanding. Outgoing tags carry the requester ID in their top
// bits; response bursts are routed back by that field.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   bot_bid/reqcyc/req/reqtag  requester-side request channel (per requester)
//   bot_reqack                 request accepted (to owner only)
//   bot_respcyc                response beat valid (to routed requester only)
//   bot_resp/resptag           response payload and original tag, broadcast
//   bot_respack                requester consumed beat
//   top_bid/reqcyc/req/reqtag  memory-side request channel, tag = {id, tag}
//   top_reqack                 memory accepted request
//   top_respcyc/resp/resptag   memory-side response channel
//   top_respack                beat consumed
//   err_orphan                 pulse per dropped orphan beat
module muskbus_tagged_arbiter
  import muskbus_pkg::*;
#(
  parameter int unsigned N          = 2,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned TAG_W      = DefTagW,
  parameter int unsigned MAX_OUT    = 4,
  parameter int unsigned RESP_BEATS = DefRespBeats,
  localparam int unsigned ID_W      = id_width(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          bot_bid,
  input  logic [N-1:0]          bot_reqcyc,
  input  logic [N*DATA_W-1:0]   bot_req,
  input  logic [N*TAG_W-1:0]    bot_reqtag,
  output logic [N-1:0]          bot_reqack,
  output logic [N-1:0]          bot_respcyc,
  output logic [N*DATA_W-1:0]   bot_resp,
  output logic [N*TAG_W-1:0]    bot_resptag,
  input  logic [N-1:0]          bot_respack,
  output logic                  top_bid,
  output logic                  top_reqcyc,
  output logic [DATA_W-1:0]     top_req,
  output logic [TAG_W+ID_W-1:0] top_reqtag,
  input  logic                  top_reqack,
  input  logic                  top_respcyc,
  input  logic [DATA_W-1:0]     top_resp,
  input  logic [TAG_W+ID_W-1:0] top_resptag,
  output logic                  top_respack,
  output logic                  err_orphan
);

  localparam int unsigned CntW  = $clog2(MAX_OUT + 1);
  localparam int unsigned BeatW = id_width(RESP_BEATS);

  req_state_e       state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]  cnt_q [N];
  logic [CntW-1:0]  cnt_d [N];
  logic [N-1:0]     cnt_inc, cnt_dec;
  logic [BeatW-1:0] beat_cnt_q, beat_cnt_d;
  logic             orphan_q, orphan_d;

  logic [N-1:0]     eligible;
  logic             pick_hit;
  logic [ID_W-1:0]  pick_idx;

  logic [ID_W-1:0]  resp_id;
  logic             id_live, sel_respack, first_beat, route_ok;
  logic             beat_take, beat_wrap;

  // ---------------------------------------------------------------- request side
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      eligible[i] = bot_bid[i] & bot_reqcyc[i] & (cnt_q[i] < CntW'(MAX_OUT));
    end
  end

  muskbus_rr_pick #(
    .N    (N),
    .ID_W (ID_W)
  ) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .hit      (pick_hit),
    .idx      (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_inc    = '0;
    bot_reqack = '0;
    top_bid    = 1'b0;
    top_reqcyc = 1'b0;
    top_req    = '0;
    top_reqtag = '0;
    case (state_q)
      StIdle: begin
        if (pick_hit) begin
          owner_d = pick_idx;
          state_d = StIssue;
        end
      end
      StIssue: begin
        top_bid    = bot_bid[owner_q];
        top_reqcyc = bot_reqcyc[owner_q];
        top_req    = bot_req[owner_q*DATA_W +: DATA_W];
        top_reqtag = {owner_q, bot_reqtag[owner_q*TAG_W +: TAG_W]};
        // A withdrawn bid wins over a same-cycle ack: nothing was issued.
        if (!bot_bid[owner_q]) begin
          state_d = StIdle;
        end else if (top_reqack) begin
          bot_reqack[owner_q] = 1'b1;
          cnt_inc[owner_q]    = 1'b1;
          rr_ptr_d            = owner_q;
          state_d             = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (reset) begin
      cnt_inc    = '0;
      bot_reqack = '0;
      top_bid    = 1'b0;
      top_reqcyc = 1'b0;
      top_req    = '0;
      top_reqtag = '0;
    end
  end

  // --------------------------------------------------------------- response side
  assign resp_id    = top_resptag[TAG_W +: ID_W];
  assign first_beat = (beat_cnt_q == '0);

  always_comb begin
    id_live     = 1'b0;
    sel_respack = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (resp_id == ID_W'(i)) begin
        id_live     = (cnt_q[i] != '0);
        sel_respack = bot_respack[i];
      end
    end
  end

  // Routing is decided on the first beat and held for the rest of the burst.
  assign route_ok = first_beat ? id_live : !orphan_q;

  always_comb begin
    bot_respcyc = '0;
    bot_resp    = '0;
    bot_resptag = '0;
    top_respack = 1'b0;
    err_orphan  = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      bot_resp[i*DATA_W +: DATA_W] = top_resp;
      bot_resptag[i*TAG_W +: TAG_W] = top_resptag[TAG_W-1:0];
      if (route_ok && resp_id == ID_W'(i)) begin
        bot_respcyc[i] = top_respcyc;
      end
    end
    if (route_ok) begin
      top_respack = sel_respack;
    end else begin
      // Nobody owns this burst: drain it and flag every beat.
      top_respack = top_respcyc;
      err_orphan  = top_respcyc;
    end
    if (reset) begin
      bot_respcyc = '0;
      bot_resp    = '0;
      bot_resptag = '0;
      top_respack = 1'b0;
      err_orphan  = 1'b0;
    end
  end

  assign beat_take = top_respcyc & top_respack;
  assign beat_wrap = beat_take && (beat_cnt_q == BeatW'(RESP_BEATS - 1));

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    orphan_d   = orphan_q;
    if (beat_take) begin
      beat_cnt_d = beat_wrap ? '0 : beat_cnt_q + 1'b1;
      if (first_beat) begin
        orphan_d = !route_ok;
      end
      if (beat_wrap) begin
        orphan_d = 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      cnt_dec[i] = beat_wrap & route_ok & (resp_id == ID_W'(i));
      cnt_d[i]   = cnt_q[i];
      if (cnt_inc[i] && !cnt_dec[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (cnt_dec[i] && !cnt_inc[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      rr_ptr_q   <= ID_W'(N - 1);
      beat_cnt_q <= '0;
      orphan_q   <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      orphan_q   <= orphan_d;
      for (int i = 0; i < int'(N); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ------------------------------------------------------------------ assertions
  for (genvar g = 0; g < int'(N); g++) begin : g_cnt_chk
    a_no_underflow : assert property (@(posedge clk) disable iff (reset)
      cnt_dec[g] |-> (cnt_q[g] != '0));
    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      cnt_q[g] <= CntW'(MAX_OUT));
  end

  a_reqack_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(bot_reqack));
  a_respcyc_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(bot_respcyc));

endmodule

// File: tb/tb_muskbus_tagged_arbiter.sv
// Directed bench for muskbus_tagged_arbiter (N=2, default widths).
module tb_muskbus_tagged_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   bot_bid, bot_reqcyc, bot_reqack, bot_respcyc, bot_respack;
  logic [127:0] bot_req, bot_resp;
  logic [25:0]  bot_reqtag, bot_resptag;
  logic         top_bid, top_reqcyc, top_reqack, top_respcyc, top_respack, err_orphan;
  logic [63:0]  top_req, top_resp;
  logic [13:0]  top_reqtag, top_resptag;

  int n_checks = 0;
  int n_errors = 0;

  muskbus_tagged_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .bot_bid     (bot_bid),
    .bot_reqcyc  (bot_reqcyc),
    .bot_req     (bot_req),
    .bot_reqtag  (bot_reqtag),
    .bot_reqack  (bot_reqack),
    .bot_respcyc (bot_respcyc),
    .bot_resp    (bot_resp),
    .bot_resptag (bot_resptag),
    .bot_respack (bot_respack),
    .top_bid     (top_bid),
    .top_reqcyc  (top_reqcyc),
    .top_req     (top_req),
    .top_reqtag  (top_reqtag),
    .top_reqack  (top_reqack),
    .top_respcyc (top_respcyc),
    .top_resp    (top_resp),
    .top_resptag (top_resptag),
    .top_respack (top_respack),
    .err_orphan  (err_orphan)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bot_bid     = '0;
    bot_reqcyc  = '0;
    bot_req     = '0;
    bot_reqtag  = '0;
    bot_respack = '0;
    top_reqack  = 1'b0;
    top_respcyc = 1'b0;
    top_resp    = '0;
    top_resptag = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  // Eight-beat burst; all beats expected accepted (routed or drained).
  task automatic burst(input logic id, input logic [12:0] tag, input logic [1:0] rack,
                       input bit orphan);
    logic [1:0] exp_cyc;
    exp_cyc = orphan ? 2'b00 : (id ? 2'b10 : 2'b01);
    for (int b = 0; b < 8; b++) begin
      top_respcyc = 1'b1;
      top_resptag = {id, tag};
      top_resp    = 64'hD00D_0000 + 64'(b);
      bot_respack = rack;
      #1;
      check_eq("burst_respcyc", bot_respcyc, exp_cyc);
      check_eq("burst_respack", top_respack, 1);
      check_eq("burst_orphan", err_orphan, orphan);
      if (!orphan) begin
        check_eq("burst_resptag", id ? bot_resptag[25:13] : bot_resptag[12:0], tag);
      end
      step();
    end
    top_respcyc = 1'b0;
    bot_respack = '0;
  endtask

  logic [13:0] exp_tag;
  logic [63:0] beat;
  bit          stall;

  initial begin
    // ---------------- reset state
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    #1;
    check_eq("rst_top_bid", top_bid, 0);
    check_eq("rst_top_reqcyc", top_reqcyc, 0);
    check_eq("rst_top_reqtag", top_reqtag, 0);
    check_eq("rst_top_respack", top_respack, 0);
    check_eq("rst_err_orphan", err_orphan, 0);
    check_eq("rst_bot_reqack", bot_reqack, 0);
    check_eq("rst_bot_respcyc", bot_respcyc, 0);
    check_eq("rst_cnt0", dut.cnt_q[0], 0);
    check_eq("rst_cnt1", dut.cnt_q[1], 0);
    check_eq("rst_rr_ptr", dut.rr_ptr_q, 1);
    check_eq("rst_beat_cnt", dut.beat_cnt_q, 0);
    reset = 1'b0;
    step();

    // ---------------- single request, tag 5 from requester 1
    bot_bid            = 2'b10;
    bot_reqcyc         = 2'b10;
    bot_reqtag[25:13]  = 13'd5;
    bot_req[127:64]    = 64'hA1;
    #1;
    check_eq("t1_grant_latency", top_reqcyc, 0);
    step();
    #1;
    check_eq("t1_issue_reqcyc", top_reqcyc, 1);
    check_eq("t1_issue_bid", top_bid, 1);
    check_eq("t1_issue_tag", top_reqtag, 14'h2005);
    check_eq("t1_issue_req", top_req, 64'hA1);
    check_eq("t1_no_ack_yet", bot_reqack, 0);
    step();
    top_reqack = 1'b1;
    #1;
    check_eq("t1_reqack", bot_reqack, 2'b10);
    step();
    idle_inputs();
    #1;
    check_eq("t1_reqack_once", bot_reqack, 0);
    check_eq("t1_cnt1_inc", dut.cnt_q[1], 1);
    check_eq("t1_cnt0_idle", dut.cnt_q[0], 0);
    burst(1'b1, 13'd5, 2'b10, 1'b0);
    #1;
    check_eq("t1_cnt1_dec", dut.cnt_q[1], 0);

    // ---------------- round-robin fairness
    do_reset();
    bot_bid    = 2'b11;
    bot_reqcyc = 2'b11;
    bot_reqtag = {13'h11, 13'h10};
    top_reqack = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1;
      check_eq("rr_idle_noack", bot_reqack, 0);
      step();
      #1;
      exp_tag = (g % 2 == 1) ? 14'h2011 : 14'h0010;
      check_eq("rr_grant", bot_reqack, (g % 2 == 1) ? 2'b10 : 2'b01);
      check_eq("rr_tag", top_reqtag, exp_tag);
      step();
    end
    idle_inputs();
    #1;
    check_eq("rr_cnt0", dut.cnt_q[0], 2);
    check_eq("rr_cnt1", dut.cnt_q[1], 2);

    // ---------------- MAX_OUT limit
    do_reset();
    bot_bid    = 2'b01;
    bot_reqcyc = 2'b01;
    top_reqack = 1'b1;
    repeat (8) step();
    #1;
    check_eq("max_cnt0_full", dut.cnt_q[0], 4);
    for (int c = 0; c < 2; c++) begin
      step();
      #1;
      check_eq("max_no_grant_cyc", top_reqcyc, 0);
      check_eq("max_no_grant_ack", bot_reqack, 0);
    end
    bot_bid    = 2'b11;
    bot_reqcyc = 2'b11;
    step();
    #1;
    check_eq("max_other_granted", bot_reqack, 2'b10);
    step();
    bot_bid    = 2'b01;
    bot_reqcyc = 2'b01;
    #1;
    check_eq("max_cnt1", dut.cnt_q[1], 1);
    burst(1'b0, 13'd9, 2'b01, 1'b0);
    #1;
    check_eq("max_after_burst_idle", top_reqcyc, 0);
    check_eq("max_cnt0_dec", dut.cnt_q[0], 3);
    step();
    #1;
    check_eq("max_regrant", bot_reqack, 2'b01);
    step();
    #1;
    check_eq("max_cnt0_refill", dut.cnt_q[0], 4);
    idle_inputs();

    // ---------------- orphan response (id 0, cnt0 == 0), requester not acking
    do_reset();
    burst(1'b0, 13'd7, 2'b00, 1'b1);
    #1;
    check_eq("orph_cnt0", dut.cnt_q[0], 0);
    check_eq("orph_cnt1", dut.cnt_q[1], 0);
    check_eq("orph_beat_cnt", dut.beat_cnt_q, 0);

    // ---------------- backpressure and same-cycle inc/dec on requester 1
    bot_bid    = 2'b10;
    bot_reqcyc = 2'b10;
    top_reqack = 1'b1;
    step();
    step();
    idle_inputs();
    #1;
    check_eq("bp_cnt1_setup", dut.cnt_q[1], 1);
    beat = 0;
    for (int cyc = 0; cyc < 11; cyc++) begin
      stall       = (cyc >= 4 && cyc <= 6);
      top_respcyc = 1'b1;
      top_resptag = {1'b1, 13'd5};
      top_resp    = 64'hB000 + beat;
      bot_respack = stall ? 2'b00 : 2'b10;
      bot_bid     = (cyc >= 9) ? 2'b10 : 2'b00;
      bot_reqcyc  = bot_bid;
      top_reqack  = (cyc == 10);
      #1;
      check_eq("bp_respcyc", bot_respcyc, 2'b10);
      check_eq("bp_respack", top_respack, !stall);
      check_eq("bp_data", bot_resp[127:64], 64'hB000 + beat);
      if (stall) check_eq("bp_beat_hold", dut.beat_cnt_q, 4);
      if (cyc == 9) check_eq("ovl_idle", top_reqcyc, 0);
      if (cyc == 10) check_eq("ovl_reqack", bot_reqack, 2'b10);
      if (!stall) beat++;
      step();
    end
    idle_inputs();
    #1;
    check_eq("ovl_cnt1_net", dut.cnt_q[1], 1);
    check_eq("bp_beat_wrap", dut.beat_cnt_q, 0);

    // ---------------- reset mid-burst
    for (int b = 0; b < 3; b++) begin
      top_respcyc = 1'b1;
      top_resptag = {1'b1, 13'd5};
      top_resp    = 64'hC000 + 64'(b);
      bot_respack = 2'b10;
      #1;
      check_eq("rm_respcyc", bot_respcyc, 2'b10);
      step();
    end
    reset = 1'b1;
    #1;
    check_eq("rm_out_respcyc", bot_respcyc, 0);
    check_eq("rm_out_respack", top_respack, 0);
    check_eq("rm_out_err", err_orphan, 0);
    check_eq("rm_out_resp", bot_resp, 0);
    check_eq("rm_out_reqcyc", top_reqcyc, 0);
    step();
    reset = 1'b0;
    for (int b = 0; b < 5; b++) begin
      #1;
      check_eq("rm_orph_respcyc", bot_respcyc, 0);
      check_eq("rm_orph_respack", top_respack, 1);
      check_eq("rm_orph_err", err_orphan, 1);
      step();
    end
    idle_inputs();
    #1;
    check_eq("rm_cnt0", dut.cnt_q[0], 0);
    check_eq("rm_cnt1", dut.cnt_q[1], 0);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
